// File: rtl/hd_pkg.sv
// Shared definitions for the hyperdimensional encoder blocks.
package hd_pkg;

  localparam int HV_DIMENSION_DEF  = 2000;
  localparam int CHANNEL_WIDTH_DEF = 4;
  localparam int MAX_MODS          = 32;

  // Per-modality channel counts, 16 bits each, modality 0 in the LSBs.
  typedef logic [16*MAX_MODS-1:0] chan_list_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINAL,
    ST_DONE
  } enc_state_e;

  function automatic int ceilLog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Number of channels preceding modality m; with m = modality count this is the total.
  function automatic int chan_offset(input chan_list_t counts, input int m);
    int s;
    s = 0;
    for (int i = 0; i < m; i++) s = s + int'(counts[16*i +: 16]);
    return s;
  endfunction

  function automatic int chan_max(input chan_list_t counts, input int n);
    int mx;
    mx = 0;
    for (int i = 0; i < n; i++)
      if (int'(counts[16*i +: 16]) > mx) mx = int'(counts[16*i +: 16]);
    return mx;
  endfunction

endpackage

// File: rtl/spatial_modality_accum.sv
// One modality: binds each fetched channel, accumulates per-bit counts,
// and thresholds them into the modality hypervector.
module spatial_modality_accum import hd_pkg::*; #(
  parameter int HV_DIMENSION = HV_DIMENSION_DEF,
  parameter int NUM_CHANNELS = 1,
  parameter int CW           = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    run_i,
  input  logic [2:0]              valid_i,
  input  logic [HV_DIMENSION-1:0] im_i,
  input  logic [HV_DIMENSION-1:0] neg_i,
  input  logic [HV_DIMENSION-1:0] pos_i,
  input  logic                    feat_msb_i,
  output logic                    req_o,
  output logic                    done_o,
  output logic [CW-1:0]           cnt_o,
  output logic [HV_DIMENSION-1:0] bit_o
);

  logic [HV_DIMENSION-1:0][CW-1:0] ctr_q, ctr_d;
  logic [HV_DIMENSION-1:0]         tie_q, tie_d, bound;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            done_q, done_d, consume;

  // req comes straight from flops, so it only moves on a consume edge
  assign req_o   = run_i & ~done_q;
  assign consume = req_o & (&valid_i);
  assign bound   = im_i ^ (feat_msb_i ? neg_i : pos_i);
  assign done_o  = done_q;
  assign cnt_o   = cnt_q;

  // accumulate one bound vector per consume; channel 0 doubles as tie-breaker
  always_comb begin
    ctr_d  = ctr_q;
    tie_d  = tie_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clear_i) begin
      ctr_d  = '0;
      tie_d  = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (consume) begin
      for (int i = 0; i < HV_DIMENSION; i++) ctr_d[i] = ctr_q[i] + CW'(bound[i]);
      if (cnt_q == '0) tie_d = bound;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(NUM_CHANNELS - 1)) done_d = 1'b1;
    end
  end

  // accumulator state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctr_q  <= '0;
      tie_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      ctr_q  <= ctr_d;
      tie_q  <= tie_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // strict majority over channels, exact half resolved by the tie vector
  always_comb begin
    bit_o = '0;
    for (int i = 0; i < HV_DIMENSION; i++)
      bit_o[i] = (int'(ctr_q[i]) * 2 > NUM_CHANNELS) |
                 ((int'(ctr_q[i]) * 2 == NUM_CHANNELS) & tie_q[i]);
  end

endmodule

// File: rtl/spatial_encoder_multimod.sv
// Multi-modality spatial encoder: sample buffer, control FSM, per-modality
// accumulators and cross-modality bitwise majority.
module spatial_encoder_multimod import hd_pkg::*; #(
  parameter int HV_DIMENSION   = HV_DIMENSION_DEF,
  parameter int CHANNEL_WIDTH  = CHANNEL_WIDTH_DEF,
  parameter int NUM_MODALITIES = 3,
  parameter logic [16*NUM_MODALITIES-1:0] MOD_CHANNELS = {16'd214, 16'd109, 16'd32},
  localparam int INPUT_CHANNELS = chan_offset(chan_list_t'(MOD_CHANNELS), NUM_MODALITIES),
  localparam int MAX_CHANNELS   = chan_max(chan_list_t'(MOD_CHANNELS), NUM_MODALITIES),
  localparam int AW = (ceilLog2(INPUT_CHANNELS) > 0) ? ceilLog2(INPUT_CHANNELS) : 1,
  localparam int CW = ceilLog2(MAX_CHANNELS + 1)
) (
  input  logic                                     Clk_CI,
  input  logic                                     Reset_RBI,
  input  logic                                     ValidIn_SI,
  output logic                                     ReadyOut_SO,
  input  logic [CHANNEL_WIDTH*INPUT_CHANNELS-1:0]  ChannelsInput_DI,
  output logic                                     ValidOut_SO,
  input  logic                                     ReadyIn_SI,
  output logic [HV_DIMENSION-1:0]                  HypervectorOut_DO,
  output logic [NUM_MODALITIES-1:0]                SramReq_SO,
  output logic [NUM_MODALITIES*AW-1:0]             SramAddr_DO,
  input  logic [3*NUM_MODALITIES-1:0]              SramValid_SI,
  input  logic [NUM_MODALITIES*HV_DIMENSION-1:0]   IMOut_DI,
  input  logic [NUM_MODALITIES*HV_DIMENSION-1:0]   ProjNeg_DI,
  input  logic [NUM_MODALITIES*HV_DIMENSION-1:0]   ProjPos_DI
);

  enc_state_e                                   state_q, state_d;
  logic [INPUT_CHANNELS-1:0]                    sign_q, sign_d;
  logic [HV_DIMENSION-1:0]                      hv_q, hv_d;
  logic                                         accept, run;
  logic [NUM_MODALITIES-1:0]                    done;
  logic [NUM_MODALITIES-1:0][HV_DIMENSION-1:0]  mod_bits;
  logic                                         unused_mag;
  int                                           ones;

  // only the sign bit of each feature selects the projection; magnitude is unused
  assign unused_mag = ^ChannelsInput_DI;
  assign accept     = ReadyOut_SO & ValidIn_SI;
  assign HypervectorOut_DO = hv_q;

  // state register
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ValidIn_SI) state_d = ST_RUN;
      ST_RUN:   if (&done)      state_d = ST_FINAL;
      ST_FINAL:                 state_d = ST_DONE;
      ST_DONE:  if (ReadyIn_SI) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ReadyOut_SO = 1'b0;
    ValidOut_SO = 1'b0;
    run         = 1'b0;
    case (state_q)
      ST_IDLE: ReadyOut_SO = 1'b1;
      ST_RUN:  run         = 1'b1;
      ST_DONE: ValidOut_SO = 1'b1;
      default: ;
    endcase
  end

  // latch feature signs on acceptance
  always_comb begin
    sign_d = sign_q;
    if (accept)
      for (int c = 0; c < INPUT_CHANNELS; c++)
        sign_d[c] = ChannelsInput_DI[c*CHANNEL_WIDTH + CHANNEL_WIDTH-1];
  end

  // bitwise majority across modalities, captured once in FINAL
  always_comb begin
    hv_d = hv_q;
    ones = 0;
    if (state_q == ST_FINAL)
      for (int i = 0; i < HV_DIMENSION; i++) begin
        ones = 0;
        for (int m = 0; m < NUM_MODALITIES; m++) ones = ones + int'(mod_bits[m][i]);
        hv_d[i] = (2 * ones > NUM_MODALITIES);
      end
  end

  // sample buffer and output register
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      sign_q <= '0;
      hv_q   <= '0;
    end else begin
      sign_q <= sign_d;
      hv_q   <= hv_d;
    end
  end

  for (genvar m = 0; m < NUM_MODALITIES; m++) begin : g_mod
    localparam int N   = int'(MOD_CHANNELS[16*m +: 16]);
    localparam int OFF = chan_offset(chan_list_t'(MOD_CHANNELS), m);
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr;

    // global channel address; meaningless once the modality is done
    assign addr = AW'(OFF) + AW'(cnt);
    assign SramAddr_DO[m*AW +: AW] = addr;

    spatial_modality_accum #(
      .HV_DIMENSION (HV_DIMENSION),
      .NUM_CHANNELS (N),
      .CW           (CW)
    ) u_acc (
      .clk_i      (Clk_CI),
      .rst_ni     (Reset_RBI),
      .clear_i    (accept),
      .run_i      (run),
      .valid_i    (SramValid_SI[3*m +: 3]),
      .im_i       (IMOut_DI[m*HV_DIMENSION +: HV_DIMENSION]),
      .neg_i      (ProjNeg_DI[m*HV_DIMENSION +: HV_DIMENSION]),
      .pos_i      (ProjPos_DI[m*HV_DIMENSION +: HV_DIMENSION]),
      .feat_msb_i (sign_q[addr]),
      .req_o      (SramReq_SO[m]),
      .done_o     (done[m]),
      .cnt_o      (cnt),
      .bit_o      (mod_bits[m])
    );
  end

endmodule

// File: tb/tb_spatial_encoder_multimod.sv
// Randomized bench: default-size encoder against a channel-level reference model,
// plus two single-modality instances for latency and tie-break corner cases.
module tb_spatial_encoder_multimod;

  localparam int HV = 2000;
  localparam int M  = 3;
  localparam int IC = 355;
  localparam int AW = 9;
  localparam int SH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- default instance ----------------
  logic              va_in, ra_out, va_out, rdy_a;
  logic [4*IC-1:0]   ch_a;
  logic [HV-1:0]     hv_a;
  logic [M-1:0]      req_a;
  logic [M*AW-1:0]   addr_a;
  logic [3*M-1:0]    sval_a;
  logic [M*HV-1:0]   im_a, neg_a, pos_a;
  logic [HV-1:0]     im_m [IC];
  logic [HV-1:0]     neg_m [IC];
  logic [HV-1:0]     pos_m [IC];
  logic [3:0]        feat [IC];
  logic [M-1:0]      ven;
  int                nch [M] = '{32, 109, 214};
  int                off [M] = '{0, 32, 141};

  spatial_encoder_multimod u_dut_a (
    .Clk_CI(clk), .Reset_RBI(rst_n), .ValidIn_SI(va_in), .ReadyOut_SO(ra_out),
    .ChannelsInput_DI(ch_a), .ValidOut_SO(va_out), .ReadyIn_SI(rdy_a),
    .HypervectorOut_DO(hv_a), .SramReq_SO(req_a), .SramAddr_DO(addr_a),
    .SramValid_SI(sval_a), .IMOut_DI(im_a), .ProjNeg_DI(neg_a), .ProjPos_DI(pos_a)
  );

  int aa;
  always_comb begin
    aa = 0;
    for (int m = 0; m < M; m++) begin
      aa = int'(addr_a[m*AW +: AW]);
      if (aa >= IC) aa = 0;
      im_a[m*HV +: HV]  = im_m[aa];
      neg_a[m*HV +: HV] = neg_m[aa];
      pos_a[m*HV +: HV] = pos_m[aa];
      sval_a[3*m +: 3]  = {3{ven[m]}};
    end
  end

  // ---------------- single modality, 3 channels ----------------
  logic          vb_in, rb_out, vb_out, rdy_b;
  logic [11:0]   ch_b;
  logic [SH-1:0] hv_b, im_b, neg_b, pos_b;
  logic [0:0]    req_b;
  logic [1:0]    addr_b;
  logic [SH-1:0] bim [3];
  logic [SH-1:0] bneg [3];
  logic [SH-1:0] bpos [3];

  spatial_encoder_multimod #(.HV_DIMENSION(SH), .NUM_MODALITIES(1), .MOD_CHANNELS(16'd3)) u_dut_b (
    .Clk_CI(clk), .Reset_RBI(rst_n), .ValidIn_SI(vb_in), .ReadyOut_SO(rb_out),
    .ChannelsInput_DI(ch_b), .ValidOut_SO(vb_out), .ReadyIn_SI(rdy_b),
    .HypervectorOut_DO(hv_b), .SramReq_SO(req_b), .SramAddr_DO(addr_b),
    .SramValid_SI(3'b111), .IMOut_DI(im_b), .ProjNeg_DI(neg_b), .ProjPos_DI(pos_b)
  );
  assign im_b  = bim[(addr_b < 2'd3) ? addr_b : 2'd0];
  assign neg_b = bneg[(addr_b < 2'd3) ? addr_b : 2'd0];
  assign pos_b = bpos[(addr_b < 2'd3) ? addr_b : 2'd0];

  // ---------------- single modality, 2 channels (even count) ----------------
  logic          vc_in, rc_out, vc_out, rdy_c;
  logic [7:0]    ch_c;
  logic [SH-1:0] hv_c, im_c, neg_c, pos_c;
  logic [0:0]    req_c;
  logic [0:0]    addr_c;
  logic [SH-1:0] cim [2];
  logic [SH-1:0] cneg [2];
  logic [SH-1:0] cpos [2];

  spatial_encoder_multimod #(.HV_DIMENSION(SH), .NUM_MODALITIES(1), .MOD_CHANNELS(16'd2)) u_dut_c (
    .Clk_CI(clk), .Reset_RBI(rst_n), .ValidIn_SI(vc_in), .ReadyOut_SO(rc_out),
    .ChannelsInput_DI(ch_c), .ValidOut_SO(vc_out), .ReadyIn_SI(rdy_c),
    .HypervectorOut_DO(hv_c), .SramReq_SO(req_c), .SramAddr_DO(addr_c),
    .SramValid_SI(3'b111), .IMOut_DI(im_c), .ProjNeg_DI(neg_c), .ProjPos_DI(pos_c)
  );
  assign im_c  = cim[addr_c];
  assign neg_c = cneg[addr_c];
  assign pos_c = cpos[addr_c];

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SH-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: bind every channel, per-modality majority with channel-0 tie-break,
  // then majority across modalities.
  function automatic logic [HV-1:0] model_a();
    logic [HV-1:0] bv [IC];
    logic [HV-1:0] r;
    int votes, ones;
    logic mb;
    r = '0;
    for (int c = 0; c < IC; c++)
      bv[c] = im_m[c] ^ (($signed(feat[c]) < 0) ? neg_m[c] : pos_m[c]);
    for (int i = 0; i < HV; i++) begin
      votes = 0;
      for (int m = 0; m < M; m++) begin
        ones = 0;
        for (int c = off[m]; c < off[m] + nch[m]; c++) ones += int'(bv[c][i]);
        if (2 * ones == nch[m]) mb = bv[off[m]][i];
        else                    mb = (2 * ones > nch[m]);
        votes += int'(mb);
      end
      r[i] = (2 * votes > M);
    end
    return r;
  endfunction

  task automatic fill_a();
    for (int c = 0; c < IC; c++) begin
      for (int i = 0; i < HV; i++) begin
        im_m[c][i]  = 1'($urandom);
        neg_m[c][i] = 1'($urandom);
        pos_m[c][i] = 1'($urandom);
      end
      feat[c] = 4'($urandom);
      ch_a[4*c +: 4] = feat[c];
    end
  endtask

  // Accept one sample, optionally stall modality 1 for 10 cycles starting at stall_at.
  task automatic run_a(input int stall_at, output int lat);
    logic [AW-1:0] a0, a1;
    va_in = 1'b1;
    step();
    va_in = 1'b0;
    lat = 0;
    while (!va_out && lat < 2000) begin
      step();
      lat++;
      if (lat == stall_at) begin
        a0 = addr_a[0 +: AW];
        a1 = addr_a[AW +: AW];
        ven[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
          step();
          lat++;
          chk("stall_addr1_frozen", addr_a[AW +: AW], a1);
          chk("stall_req1_held", req_a[1], 1'b1);
        end
        ven[1] = 1'b1;
        chk("stall_mod0_advanced", addr_a[0 +: AW], a0 + AW'(10));
      end
    end
    chk("a_valid_seen", va_out, 1'b1);
  endtask

  task automatic run_c(input logic [7:0] ch, output int lat);
    ch_c  = ch;
    vc_in = 1'b1;
    step();
    vc_in = 1'b0;
    lat = 0;
    while (!vc_out && lat < 50) begin
      step();
      lat++;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [HV-1:0] exp_a;
  logic [SH-1:0] b0, b1, b2, r;
  int lat, bad;

  initial begin
    va_in = 0; rdy_a = 0; ch_a = '0; ven = '1;
    vb_in = 0; rdy_b = 0; ch_b = '0;
    vc_in = 0; rdy_c = 0; ch_c = '0;
    for (int c = 0; c < IC; c++) begin
      im_m[c] = '0; neg_m[c] = '0; pos_m[c] = '0; feat[c] = '0;
    end
    for (int c = 0; c < 3; c++) begin bim[c] = '0; bneg[c] = '0; bpos[c] = '0; end
    for (int c = 0; c < 2; c++) begin cim[c] = '0; cneg[c] = '0; cpos[c] = '0; end

    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", ra_out, 1'b1);
    chk("rst_valid", va_out, 1'b0);
    chk("rst_req", req_a, 3'b000);
    chk("rst_hv", hv_a[63:0], 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // three channels, features +1,-1,+1
    for (int c = 0; c < 3; c++) begin bim[c] = rnd64(); bneg[c] = rnd64(); bpos[c] = rnd64(); end
    ch_b = {4'h1, 4'hF, 4'h1};
    vb_in = 1'b1;
    step();
    vb_in = 1'b0;
    lat = 0;
    while (!vb_out && lat < 50) begin step(); lat++; end
    chk("b_latency", lat, 5);
    b0 = bim[0] ^ bpos[0];
    b1 = bim[1] ^ bneg[1];
    b2 = bim[2] ^ bpos[2];
    chk("b_hv", hv_b, (b0 & b1) | (b0 & b2) | (b1 & b2));
    rdy_b = 1'b1; step(); rdy_b = 1'b0;

    // even count: b0 all ones, b1 all zeros -> every bit is a tie, result follows b0
    cim[0] = rnd64(); cim[1] = rnd64(); cneg[0] = rnd64(); cneg[1] = rnd64();
    cpos[0] = ~cim[0];
    cpos[1] = cim[1];
    run_c({4'h1, 4'h1}, lat);
    chk("c_latency", lat, 4);
    chk("c_tie_ones", hv_c, {SH{1'b1}});
    rdy_c = 1'b1; step(); rdy_c = 1'b0;

    // even count, channel 0 negative: b0 = r, b1 = ~r -> result r
    r = rnd64();
    cim[0] = rnd64(); cim[1] = rnd64(); cpos[0] = rnd64(); cneg[1] = rnd64();
    cneg[0] = cim[0] ^ r;
    cpos[1] = cim[1] ^ ~r;
    run_c({4'h2, 4'hD}, lat);
    chk("c_tie_random", hv_c, r);
    rdy_c = 1'b1; step(); rdy_c = 1'b0;

    // default configuration, no stalls
    fill_a();
    exp_a = model_a();
    run_a(0, lat);
    chk("a_latency", lat, 216);
    chk("a_hv_bitdiff", $countones(hv_a ^ exp_a), 0);

    // hold in DONE with a competing sample offered
    va_in = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (hv_a !== exp_a || ra_out !== 1'b0 || va_out !== 1'b1) bad++;
    end
    chk("hold_stable_cycles_bad", bad, 0);
    va_in = 1'b0;
    rdy_a = 1'b1; step(); rdy_a = 1'b0;
    chk("back_to_idle_ready", ra_out, 1'b1);
    chk("back_to_idle_valid", va_out, 1'b0);

    // same sample, modality 1 stalled mid-run
    run_a(5, lat);
    chk("stall_latency_window", (lat >= 216 && lat <= 226), 1'b1);
    chk("stall_hv_bitdiff", $countones(hv_a ^ exp_a), 0);
    rdy_a = 1'b1; step(); rdy_a = 1'b0;

    // asynchronous reset in the middle of RUN
    fill_a();
    exp_a = model_a();
    va_in = 1'b1; step(); va_in = 1'b0;
    repeat (50) step();
    chk("mid_run_req_active", req_a[2], 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", ra_out, 1'b1);
    chk("async_rst_valid", va_out, 1'b0);
    chk("async_rst_req", req_a, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_no_output", va_out, 1'b0);
    run_a(0, lat);
    chk("post_rst_latency", lat, 216);
    chk("post_rst_hv_bitdiff", $countones(hv_a ^ exp_a), 0);
    rdy_a = 1'b1; step(); rdy_a = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
